// File: rtl/hilo_md_unit_pkg.sv
// md_pkg: mult/div op encodings and default busy-cycle counts for hilo_md_unit.
package md_pkg;
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/hilo_md_unit_if.sv
// hilo_md_unit_if: EX-stage issue bus and HI/LO/busy/stall return path of the mult/div unit.
interface hilo_md_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output start, op, src_a, src_b, md_use, input busy, stall, hi, lo);
    modport slave  (input start, op, src_a, src_b, md_use, output busy, stall, hi, lo);
endinterface

// File: rtl/hilo_md_unit_calc.sv
// md_calc: combinational next-{hi,lo} for a latched mult/div op, holding HI/LO on divide by zero.
module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n
);
    logic [63:0] ps;
    logic [63:0] pu;
    logic [31:0] qs;
    logic [31:0] rs;
    logic [31:0] qu;
    logic [31:0] ru;
    always_comb begin
        ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        pu = {32'b0, a} * {32'b0, b};
        // 33-bit signed divide: 0x80000000 / -1 yields 2^31, truncating to lo=0x80000000, hi=0
        qs = 32'($signed({a[31], a}) / $signed({b[31], b}));
        rs = 32'($signed({a[31], a}) % $signed({b[31], b}));
        qu = a / b;
        ru = a % b;
        {hi_n, lo_n} = op == MD_MULT                 ? ps :
                       op == MD_MULTU                ? pu :
                       op == MD_DIV  && b != 32'd0   ? {rs, qs} :
                       op == MD_DIVU && b != 32'd0   ? {ru, qu} : {hi, lo};
    end
endmodule

// File: rtl/hilo_md_unit.sv
// hilo_md_unit: HI/LO register pair with multi-cycle mult/div sequencing and EX-stage stall.
module hilo_md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    hilo_md_unit_if.slave  bus
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   hi_n;
    logic [31:0]   lo_n;
    logic          is_mul;
    logic          is_div;
    assign is_mul    = bus.op == MD_MULT || bus.op == MD_MULTU;
    assign is_div    = bus.op == MD_DIV  || bus.op == MD_DIVU;
    assign bus.busy  = cnt != '0;
    assign bus.stall = bus.md_use & bus.busy;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    md_calc u_calc (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .hi   (hi_q),
        .lo   (lo_q),
        .hi_n (hi_n),
        .lo_n (lo_n)
    );
    // Issue only when idle; a start during busy is dropped since the stall keeps it from happening.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else if (bus.busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                hi_q <= hi_n;
                lo_q <= lo_n;
            end
        end else if (bus.start) begin
            if (is_mul || is_div) begin
                op_q <= bus.op;
                a_q  <= bus.src_a;
                b_q  <= bus.src_b;
                cnt  <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end
            if (bus.op == MD_MTHI) hi_q <= bus.src_a;
            if (bus.op == MD_MTLO) lo_q <= bus.src_a;
        end
    end
endmodule

// File: tb/tb_hilo_md_unit.sv
// tb_hilo_md_unit: scenario-task bench with an expected-{hi,lo} scoreboard queue.
module tb_hilo_md_unit;
    import md_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];
    always #5 clk = ~clk;
    hilo_md_unit_if bus();
    hilo_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = o;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic run_md(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [63:0] e);
        int c = 0;
        logic [63:0] x;
        exp_q.push_back(e);
        issue(o, a, b);
        @(negedge clk);
        while (bus.busy && c < 40) begin
            c++;
            @(negedge clk);
        end
        tests++;
        if (c !== n) begin
            fails++;
            $display("FAIL %s busy_cycles got %0d want %0d", name, c, n);
        end
        x = exp_q.pop_front();
        tests++;
        if ({bus.hi, bus.lo} !== x) begin
            fails++;
            $display("FAIL %s hilo got %h want %h", name, {bus.hi, bus.lo}, x);
        end
    endtask

    task automatic test_reset();
        bus.md_use = 1'b1;
        #3;
        tests++;
        if ({bus.busy, bus.stall, bus.hi, bus.lo} !== 66'b0) begin
            fails++;
            $display("FAIL reset busy=%b stall=%b hi=%h lo=%h want all 0", bus.busy, bus.stall, bus.hi, bus.lo);
        end
        bus.md_use = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult();
        logic [31:0] a;
        logic [31:0] b;
        run_md("mult_neg", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 64'hFFFFFFFF_FFFFFFFA);
        run_md("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3, 5, 64'h00000002_FFFFFFFA);
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            run_md("mult_rand", MD_MULT, a, b, 5, longint'($signed(a)) * longint'($signed(b)));
            run_md("multu_rand", MD_MULTU, a, b, 5, {32'b0, a} * {32'b0, b});
        end
    endtask

    task automatic test_div();
        run_md("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 64'hFFFFFFFF_FFFFFFFD);
        run_md("divu", MD_DIVU, 32'd7, 32'd2, 10, 64'h00000001_00000003);
    endtask

    task automatic test_mthi_mtlo(input logic [31:0] h, input logic [31:0] l, input logic [31:0] lo_prev);
        logic [63:0] x;
        exp_q.push_back({h, lo_prev});
        exp_q.push_back({h, l});
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = MD_MTHI;
        bus.src_a = h;
        @(negedge clk);
        bus.op = MD_MTLO;
        bus.src_a = l;
        x = exp_q.pop_front();
        tests++;
        if ({bus.busy, bus.hi, bus.lo} !== {1'b0, x}) begin
            fails++;
            $display("FAIL mthi busy=%b hilo got %h want %h", bus.busy, {bus.hi, bus.lo}, x);
        end
        @(negedge clk);
        bus.start = 1'b0;
        x = exp_q.pop_front();
        tests++;
        if ({bus.busy, bus.hi, bus.lo} !== {1'b0, x}) begin
            fails++;
            $display("FAIL mtlo busy=%b hilo got %h want %h", bus.busy, {bus.hi, bus.lo}, x);
        end
    endtask

    task automatic test_div_special();
        test_mthi_mtlo(32'd5, 32'd6, 32'h9ABCDEF0);
        run_md("div_by_zero", MD_DIV, 32'd100, 32'd0, 10, 64'h00000005_00000006);
        run_md("divu_by_zero", MD_DIVU, 32'd100, 32'd0, 10, 64'h00000005_00000006);
        run_md("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 64'h00000000_80000000);
        issue(3'd6, 32'hDEADBEEF, 32'd1);
        issue(3'd7, 32'hDEADBEEF, 32'd1);
        @(negedge clk);
        tests++;
        if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 64'h00000000_80000000}) begin
            fails++;
            $display("FAIL undef_op busy=%b hilo got %h want 0000000080000000", bus.busy, {bus.hi, bus.lo});
        end
    endtask

    task automatic test_stall_back_to_back();
        int c = 0;
        logic [63:0] x;
        exp_q.push_back(64'd20);
        issue(MD_MULT, 32'd4, 32'd5);
        for (int i = 1; i <= 5; i++) begin
            bus.md_use = (i >= 2 && i <= 4);
            bus.start = (i == 3);
            bus.op = MD_MTHI;
            bus.src_a = 32'hDEAD0000;
            @(negedge clk);
            tests++;
            if ({bus.busy, bus.stall} !== {1'b1, (i >= 2 && i <= 4)}) begin
                fails++;
                $display("FAIL stall cycle %0d busy=%b stall=%b want busy=1 stall=%b", i, bus.busy, bus.stall, (i >= 2 && i <= 4));
            end
            @(posedge clk);
            #1;
        end
        bus.md_use = 1'b1;
        bus.start = 1'b1;
        bus.op = MD_MULTU;
        bus.src_a = 32'd6;
        bus.src_b = 32'd7;
        @(negedge clk);
        x = exp_q.pop_front();
        tests++;
        if ({bus.busy, bus.stall, bus.hi, bus.lo} !== {2'b00, x}) begin
            fails++;
            $display("FAIL mult_commit busy=%b stall=%b hilo got %h want %h", bus.busy, bus.stall, {bus.hi, bus.lo}, x);
        end
        exp_q.push_back(64'd42);
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.md_use = 1'b0;
        @(negedge clk);
        while (bus.busy && c < 40) begin
            c++;
            @(negedge clk);
        end
        tests++;
        if (c !== 5) begin
            fails++;
            $display("FAIL back_to_back busy_cycles got %0d want 5", c);
        end
        x = exp_q.pop_front();
        tests++;
        if ({bus.hi, bus.lo} !== x) begin
            fails++;
            $display("FAIL back_to_back hilo got %h want %h", {bus.hi, bus.lo}, x);
        end
    endtask

    task automatic test_async_reset();
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL async_pre busy got %b want 1", bus.busy);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({bus.busy, bus.hi, bus.lo} !== 65'b0) begin
            fails++;
            $display("FAIL async_reset busy=%b hilo got %h want 0", bus.busy, {bus.hi, bus.lo});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        tests++;
        if ({bus.busy, bus.hi, bus.lo} !== 65'b0) begin
            fails++;
            $display("FAIL after_reset busy=%b hilo got %h want 0", bus.busy, {bus.hi, bus.lo});
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.src_a = 32'd0;
        bus.src_b = 32'd0;
        bus.md_use = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo(32'h12345678, 32'h9ABCDEF0, 32'h00000003);
        test_div_special();
        test_stall_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hilo_md_unit.md
# hilo_md_unit

Multiply/divide unit with its HI/LO register pair, sequencing multi-cycle mult/div operations issued from the EX stage. It owns the busy counter, latches operands at issue, commits results to HI/LO after a fixed latency, and raises a stall to the hazard unit when a HI/LO-using instruction reaches EX while an operation is in flight. HI/LO outputs feed the EX/MEM pipeline register's HI_LO field for mfhi/mflo.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted; clears state immediately, independent of clk)
- start  in  1  issue strobe from EX stage; sampled on rising clk edge
- op  in  3  operation code (md_pkg encodings), valid with start
- src_a  in  32  rs operand (forwarded)
- src_b  in  32  rt operand (forwarded)
- md_use  in  1  instruction in EX is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  multi-cycle operation in progress
- stall  out  1  freeze F/D/E, bubble into MEM; = md_use & busy
- hi  out  32  current HI register
- lo  out  32  current LO register

## Operation
- State: cnt (4 bits, sized for max(MULT_CYCLES, DIV_CYCLES)), op_q, a_q, b_q, hi, lo.
- busy = (cnt != 0); purely from registered cnt, no combinational path from start.
- Issue accepted at an edge where start=1 and busy=0; start while busy=1 is ignored (the stall guarantees it never occurs; bench flags it).
- MULT/MULTU/DIV/DIVU accept: a_q<=src_a, b_q<=src_b, op_q<=op, cnt<=MULT_CYCLES or DIV_CYCLES.
- MTHI accept: hi<=src_a at that edge; MTLO: lo<=src_a. cnt stays 0, no busy.
- Undefined op codes (6,7) with start: no state change.
- Each edge with cnt≠0: cnt<=cnt-1. At edge with cnt==1: commit result, cnt<=0.
- Results from latched operands:
  - MULT: {hi,lo} <= signed 32×32→64 product; MULTU: unsigned.
  - DIV: lo <= signed quotient truncated toward zero, hi <= remainder with sign of dividend; DIVU: unsigned.
  - Divisor zero (div/divu): hi, lo unchanged; operation still occupies DIV_CYCLES.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- mfhi/mflo are not handled here beyond stall; EX reads hi/lo directly.

## Timing
- Reset values (asynchronous, while reset=0): cnt=0, busy=0, stall=0, hi=0, lo=0, op_q/a_q/b_q=0.
- Reset mid-operation: in-flight result discarded, HI/LO cleared; first valid issue possible on first rising edge with reset=1.
- Mult/div issued at edge k: busy=1 for exactly N cycles (after edges k..k+N-1); HI/LO updated at edge k+N and visible with busy=0 in the same cycle.
- Back-to-back: a new start in the first busy=0 cycle is accepted at that edge; no dead cycle.
- mthi/mtlo: 1-edge latency, visible the cycle after issue.
- stall is combinational in md_use and registered busy only.

## Structure
- Package md_pkg: op encodings MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5; default cycle counts.
- One sub-module md_calc: combinational, inputs op_q/a_q/b_q/hi/lo, outputs next {hi,lo} including div-by-zero hold and overflow case. Counter, issue and commit logic stay in hilo_md_unit.

## Test plan
- Reset then MULT src_a=0xFFFFFFFE (-2), src_b=3 -> busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV src_a=-7 (0xFFFFFFF9), src_b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive edges -> busy never high; hi/lo show values one cycle after each issue.
- DIV by zero with hi=5, lo=6 preloaded -> busy 10 cycles, hi=5, lo=6 unchanged; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT issued, md_use=1 on cycles 2-4 -> stall=1 exactly those cycles; start pulsed mid-busy with op=MTHI -> ignored, hi unchanged; start in first busy=0 cycle -> accepted.
- Drop reset to 0 asynchronously in cycle 3 of a DIV -> busy, hi, lo go 0 without a clock edge; after release no commit occurs.
